// File: rtl/conv_geom_pkg.sv
// rtl/conv_geom_pkg.sv - shared convolution geometry constants, width helpers and walker state type
package conv_geom_pkg;

    localparam int DEF_IFMAP_H  = 5;
    localparam int DEF_IFMAP_W  = 5;
    localparam int DEF_IFMAP_C  = 1;
    localparam int DEF_FILTER_W = 3;

    // Valid-convolution output size for an input edge and a square filter edge
    function automatic int out_dim(input int in_dim, input int k);
        return in_dim - k + 1;
    endfunction

    localparam int DEF_OH = out_dim(DEF_IFMAP_H, DEF_FILTER_W);
    localparam int DEF_OW = out_dim(DEF_IFMAP_W, DEF_FILTER_W);

    // Width needed to index n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } walk_state_e;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MAX up counter with clear, increment and last-value flag
module wrap_counter #(
    parameter int MAX = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = (count == LAST);

    // Clear has priority; increment rolls over to zero after the last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ifmap_addr_walker.sv
// rtl/ifmap_addr_walker.sv - raster walker over IFMAP RAM with matching OFMAP address; optional OFMAP_CHAN_OFFSET_EN
module ifmap_addr_walker
    import conv_geom_pkg::*;
#(
    parameter int IFMAP_H   = DEF_IFMAP_H,
    parameter int IFMAP_W   = DEF_IFMAP_W,
    parameter int IFMAP_C   = DEF_IFMAP_C,
    parameter int FILTER_W  = DEF_FILTER_W,
    parameter int ADDR_W    = clog2_min1(IFMAP_H * IFMAP_W * IFMAP_C),
    parameter int OF_ADDR_W = clog2_min1(out_dim(IFMAP_H, FILTER_W) *
                                         out_dim(IFMAP_W, FILTER_W) * IFMAP_C)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             addr_valid,
    input  logic                             addr_ready,
    output logic [ADDR_W-1:0]                image_ram_addr,
    output logic [clog2_min1(IFMAP_W)-1:0]   x_idx,
    output logic [clog2_min1(IFMAP_H)-1:0]   y_idx,
    output logic [clog2_min1(IFMAP_C)-1:0]   c_idx,
    output logic                             last_col,
    output logic                             last_row,
    output logic                             last_channel,
    output logic                             ofmap_valid,
    output logic [OF_ADDR_W-1:0]             feature_ram_addr
);

    localparam int XW = clog2_min1(IFMAP_W);
    localparam int YW = clog2_min1(IFMAP_H);
    localparam int CW = clog2_min1(IFMAP_C);

    // First column/row at which a full KxK window has been seen
    localparam logic [XW-1:0] X_MIN = XW'(FILTER_W - 1);
    localparam logic [YW-1:0] Y_MIN = YW'(FILTER_W - 1);

    walk_state_e          state_q, state_d;
    logic                 clr;
    logic                 fire;
    logic                 last_all;
    logic                 feat_restart;
    logic [OF_ADDR_W-1:0] feat_cnt;

    assign busy       = (state_q == RUN);
    assign addr_valid = (state_q == RUN);
    assign done       = (state_q == DONE);

    assign fire     = addr_valid && addr_ready && !abort;
    assign last_all = last_col && last_row && last_channel;

    assign ofmap_valid      = addr_valid && (x_idx >= X_MIN) && (y_idx >= Y_MIN);
    assign feature_ram_addr = ofmap_valid ? feat_cnt : '0;

`ifdef OFMAP_CHAN_OFFSET_EN
    // Depthwise: each channel continues into its own OFMAP plane
    assign feat_restart = last_all;
`else
    // Every channel folds onto the same OFMAP plane for accumulation
    assign feat_restart = last_col && last_row;
`endif

    wrap_counter #(.MAX(IFMAP_W), .W(XW)) u_x_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fire),
        .count (x_idx),
        .wrap  (last_col)
    );

    wrap_counter #(.MAX(IFMAP_H), .W(YW)) u_y_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fire && last_col),
        .count (y_idx),
        .wrap  (last_row)
    );

    wrap_counter #(.MAX(IFMAP_C), .W(CW)) u_c_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fire && last_col && last_row),
        .count (c_idx),
        .wrap  (last_channel)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort beats start and clears all counters
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    clr = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (fire && last_all) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                clr     = abort;
            end
            default: begin
                state_d = IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    // Linear image address advances by one per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            image_ram_addr <= '0;
        end else if (clr) begin
            image_ram_addr <= '0;
        end else if (fire) begin
            image_ram_addr <= last_all ? '0 : image_ram_addr + 1'b1;
        end
    end

    // OFMAP address advances only past beats that closed a window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_cnt <= '0;
        end else if (clr) begin
            feat_cnt <= '0;
        end else if (fire) begin
            if (feat_restart) begin
                feat_cnt <= '0;
            end else if (ofmap_valid) begin
                feat_cnt <= feat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_addr_walker.sv
// tb/tb_ifmap_addr_walker.sv - directed self-checking bench for ifmap_addr_walker
module tb_ifmap_addr_walker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 5x5x1, K=3 instance
    logic       start0, abort0, ready0;
    logic       busy0, done0, valid0;
    logic [4:0] addr0;
    logic [2:0] x0, y0;
    logic [0:0] c0;
    logic       lc0, lr0, lch0, ov0;
    logic [3:0] fa0;

    // 4x6x2, K=3 instance
    logic       start1, abort1, ready1;
    logic       busy1, done1, valid1;
    logic [5:0] addr1;
    logic [2:0] x1;
    logic [1:0] y1;
    logic [0:0] c1;
    logic       lc1, lr1, lch1, ov1;
    logic [3:0] fa1;

    int checks   = 0;
    int failures = 0;

    ifmap_addr_walker u_dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start0),
        .abort            (abort0),
        .busy             (busy0),
        .done             (done0),
        .addr_valid       (valid0),
        .addr_ready       (ready0),
        .image_ram_addr   (addr0),
        .x_idx            (x0),
        .y_idx            (y0),
        .c_idx            (c0),
        .last_col         (lc0),
        .last_row         (lr0),
        .last_channel     (lch0),
        .ofmap_valid      (ov0),
        .feature_ram_addr (fa0)
    );

    ifmap_addr_walker #(
        .IFMAP_H  (4),
        .IFMAP_W  (6),
        .IFMAP_C  (2),
        .FILTER_W (3)
    ) u_dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start1),
        .abort            (abort1),
        .busy             (busy1),
        .done             (done1),
        .addr_valid       (valid1),
        .addr_ready       (ready1),
        .image_ram_addr   (addr1),
        .x_idx            (x1),
        .y_idx            (y1),
        .c_idx            (c1),
        .last_col         (lc1),
        .last_row         (lr1),
        .last_channel     (lch1),
        .ofmap_valid      (ov1),
        .feature_ram_addr (fa1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int exp_f38, exp_f47;

    initial begin
`ifdef OFMAP_CHAN_OFFSET_EN
        exp_f38 = 8;
        exp_f47 = 15;
`else
        exp_f38 = 0;
        exp_f47 = 7;
`endif
        rst_n  = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", valid0, 0);
        check("rst_busy",  busy0,  0);
        check("rst_done",  done0,  0);
        check("rst_addr",  addr0,  0);
        check("rst_lcol",  lc0,    0);
        check("rst_ofv",   ov0,    0);
        check("rst_feat",  fa0,    0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", valid0, 0);

        // Full walk, ready held high; a stray start mid-walk is ignored
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            int xe, ye, ove, fe;
            xe  = i % 5;
            ye  = i / 5;
            ove = (xe >= 2 && ye >= 2) ? 1 : 0;
            fe  = ove ? (ye - 2) * 3 + (xe - 2) : 0;
            check("w1_addr",  addr0,  i);
            check("w1_valid", valid0, 1);
            check("w1_x",     x0,     xe);
            check("w1_y",     y0,     ye);
            check("w1_ofv",   ov0,    ove);
            check("w1_feat",  fa0,    fe);
            if (i == 4)  begin check("a4_lcol", lc0, 1);  check("a4_lrow", lr0, 0); end
            if (i == 20) begin check("a20_lrow", lr0, 1); check("a20_lcol", lc0, 0); end
            if (i == 24) begin
                check("a24_lcol", lc0, 1); check("a24_lrow", lr0, 1); check("a24_lch", lch0, 1);
            end
            start0 = (i == 5);
            @(negedge clk);
        end
        start0 = 1'b0;
        check("w1_done",       done0,  1);
        check("w1_done_valid", valid0, 0);
        @(negedge clk);
        check("w1_done_pulse", done0, 0);
        check("w1_idle_busy",  busy0, 0);

        // Backpressure on address 7, then abort at address 10
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);
        check("bp_addr7", addr0, 7);
        ready0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_addr",  addr0,  7);
            check("bp_hold_x",     x0,     2);
            check("bp_hold_y",     y0,     1);
            check("bp_hold_valid", valid0, 1);
        end
        ready0 = 1'b1;
        @(negedge clk);
        check("bp_next", addr0, 8);
        repeat (2) @(negedge clk);
        check("ab_addr10", addr0, 10);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        check("ab_valid", valid0, 0);
        check("ab_busy",  busy0,  0);
        check("ab_done",  done0,  0);
        check("ab_addr",  addr0,  0);
        @(negedge clk);
        check("ab_done2", done0, 0);

        // abort together with start in IDLE keeps the walker idle
        abort0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0; start0 = 1'b0;
        check("as_valid", valid0, 0);
        check("as_busy",  busy0,  0);

        // Restart from zero, then reset mid-walk
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("rs_addr0",  addr0,  0);
        check("rs_valid",  valid0, 1);
        repeat (3) @(negedge clk);
        check("rs_addr3", addr0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mr_addr",  addr0,  0);
        check("mr_valid", valid0, 0);
        check("mr_busy",  busy0,  0);
        check("mr_x",     x0,     0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_done", done0, 0);

        // 4x6x2 multi-channel walk
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 48; i++) begin
            check("m_addr", addr1, i);
            if (i == 37) check("m37_ofv", ov1, 0);
            if (i == 38) begin
                check("m38_c",    c1,  1);
                check("m38_y",    y1,  2);
                check("m38_x",    x1,  2);
                check("m38_ofv",  ov1, 1);
                check("m38_feat", fa1, exp_f38);
            end
            if (i == 47) begin
                check("m47_ofv",  ov1,  1);
                check("m47_feat", fa1,  exp_f47);
                check("m47_lch",  lch1, 1);
            end
            @(negedge clk);
        end
        check("m_done",  done1,  1);
        check("m_valid", valid1, 0);
        @(negedge clk);
        check("m_done_pulse", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
